// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: RV32I major opcodes, FSM states
// and the writeback / PC-source mux selects consumed by the datapath.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpIarith = 7'b0010011;
  localparam logic [6:0] OpIload  = 7'b0000011;
  localparam logic [6:0] OpStype  = 7'b0100011;
  localparam logic [6:0] OpBtype  = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StIoWait = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;
  localparam logic [1:0] WbIo  = 2'd3;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcImm    = 2'd1;
  localparam logic [1:0] PcRs1Imm = 2'd2;

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OpRtype, OpIarith, OpIload, OpStype, OpBtype,
      OpJal, OpJalr, OpLui, OpAuipc, OpEcall: op_known = 1'b1;
      default:                                op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: steps each instruction through fetch, decode, execute,
// memory/IO and writeback with variable-latency handshakes, and counts retirements.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 io_ack,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 io_req,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (pc_write) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    io_req    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WbAlu;
    pc_write  = 1'b0;
    pc_src    = PcPlus4;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (op_known(opcode)) begin
          state_d = StExec;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        case (opcode)
          OpBtype: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PcImm : PcPlus4;
            state_d  = StFetch;
          end
          OpIload, OpStype: state_d = StMem;
          OpEcall:          state_d = StIoWait;
          default:          state_d = StWb;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OpStype);
        if (dmem_ready) begin
          if (opcode == OpStype) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d  = StWb;
          end
        end
      end
      StIoWait: begin
        io_req = 1'b1;
        if (io_ack) state_d = StWb;
      end
      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (opcode)
          OpIload:       wb_sel = WbMem;
          OpJal, OpJalr: wb_sel = WbPc4;
          OpEcall:       wb_sel = WbIo;
          default:       wb_sel = WbAlu;
        endcase
        case (opcode)
          OpJal:   pc_src = PcImm;
          OpJalr:  pc_src = PcRs1Imm;
          default: pc_src = PcPlus4;
        endcase
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase

    // Reset silences every request immediately, even mid-handshake.
    if (!rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      io_req    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WbAlu;
      pc_write  = 1'b0;
      pc_src    = PcPlus4;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push per-cycle expected
// output vectors; a negedge monitor pops and compares while memory responders run.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int unsigned IW = 3;

  localparam logic [6:0] FIMR = 7'b1000000;
  localparam logic [6:0] FIRW = 7'b0100000;
  localparam logic [6:0] FDMR = 7'b0010000;
  localparam logic [6:0] FDWE = 7'b0001000;
  localparam logic [6:0] FIOR = 7'b0000100;
  localparam logic [6:0] FRW  = 7'b0000010;
  localparam logic [6:0] FPW  = 7'b0000001;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          imem_ready, dmem_ready, io_ack;
  logic          imem_req, ir_write, dmem_req, dmem_we, io_req, reg_write, pc_write;
  logic [1:0]    wb_sel, pc_src;
  logic          illegal;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .io_ack       (io_ack),
    .imem_req     (imem_req),
    .ir_write     (ir_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .io_req       (io_req),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .illegal      (illegal),
    .state        (state),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t          q[$];
  int            ntests = 0;
  int            nfail  = 0;
  int            pend   = 0;
  int            iwait  = 0, dwait = 0, await_n = 0;
  bit            noise  = 1'b0;
  logic          exp_ill = 1'b0;
  logic [IW-1:0] exp_cnt = '0;

  function automatic string fmt(input logic [17:0] v);
    return $sformatf("st=%0d req/irw/dreq/we/io/rw/pw=%b wb=%0d pcs=%0d ill=%b ir=%0d",
                     v[17:15], v[14:8], v[7:6], v[5:4], v[3], v[2:0]);
  endfunction

  task automatic px(input string tag, input logic [2:0] st, input logic [6:0] fl,
                    input logic [1:0] wb = 2'd0, input logic [1:0] pcs = 2'd0);
    exp_t e;
    e.tag = tag;
    e.v   = {st, fl, wb, pcs, exp_ill, exp_cnt};
    q.push_back(e);
    pend++;
    if (fl[0]) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    repeat (pend) cyc();
    pend = 0;
  endtask

  task automatic fetch(input int w);
    for (int i = 0; i < w; i++) px("fetch_wait", StFetch, FIMR);
    px("fetch", StFetch, FIMR | FIRW);
    px("decode", StDecode, 7'b0);
  endtask

  // Monitor: one expected vector per clock while the scoreboard holds entries.
  initial begin
    exp_t        e;
    logic [17:0] act;
    int          n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {state, imem_req, ir_write, dmem_req, dmem_we, io_req, reg_write, pc_write,
               wb_sel, pc_src, illegal, instret};
        ntests++;
        if (act !== e.v) begin
          nfail++;
          $display("FAIL %s cycle %0d: got %s, want %s", e.tag, n, fmt(act), fmt(e.v));
        end
      end
    end
  end

  // Responders: ready/ack on the (wait+1)-th request cycle; optional stray pulses when idle.
  initial begin
    int ic = 0, dc = 0, ac = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    io_ack     = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        imem_ready = (ic == iwait);
        ic = imem_ready ? 0 : ic + 1;
      end else begin
        imem_ready = noise;
        ic = 0;
      end
      if (dmem_req) begin
        dmem_ready = (dc == dwait);
        dc = dmem_ready ? 0 : dc + 1;
      end else begin
        dmem_ready = noise;
        dc = 0;
      end
      if (io_req) begin
        io_ack = (ac == await_n);
        ac = io_ack ? 0 : ac + 1;
      end else begin
        io_ack = noise;
        ac = 0;
      end
    end
  end

  initial begin
    rst = 1'b0;
    opcode = OpRtype;
    branch_taken = 1'b0;
    cyc();
    cyc();
    px("reset_state", StFetch, 7'b0);
    go();
    rst = 1'b1;

    // add, zero wait: 0,1,2,4
    opcode = OpRtype;
    fetch(0);
    px("add_exec", StExec, 7'b0);
    px("add_wb", StWb, FRW | FPW, WbAlu, PcPlus4);
    go();

    // addi with 2 fetch wait cycles and stray dmem/io pulses
    noise = 1'b1; iwait = 2; opcode = OpIarith;
    fetch(2);
    px("addi_exec", StExec, 7'b0);
    px("addi_wb", StWb, FRW | FPW, WbAlu, PcPlus4);
    go();
    noise = 1'b0; iwait = 0;

    // lw, dmem_ready delayed 3 cycles: 8 cycles total
    dwait = 3; opcode = OpIload;
    fetch(0);
    px("lw_exec", StExec, 7'b0);
    for (int i = 0; i < 4; i++) px("lw_mem", StMem, FDMR);
    px("lw_wb", StWb, FRW | FPW, WbMem, PcPlus4);
    go();

    // sw, zero wait: 4 cycles
    dwait = 0; opcode = OpStype;
    fetch(0);
    px("sw_exec", StExec, 7'b0);
    px("sw_mem", StMem, FDMR | FDWE | FPW, WbAlu, PcPlus4);
    go();

    // branch taken then not taken
    opcode = OpBtype; branch_taken = 1'b1;
    fetch(0);
    px("beq_taken", StExec, FPW, WbAlu, PcImm);
    go();
    branch_taken = 1'b0;
    fetch(0);
    px("beq_not_taken", StExec, FPW, WbAlu, PcPlus4);
    go();

    // jalr then jal; instret reaches all-ones and wraps on the jal
    opcode = OpJalr;
    fetch(0);
    px("jalr_exec", StExec, 7'b0);
    px("jalr_wb", StWb, FRW | FPW, WbPc4, PcRs1Imm);
    go();
    opcode = OpJal;
    fetch(0);
    px("jal_exec", StExec, 7'b0);
    px("jal_wb", StWb, FRW | FPW, WbPc4, PcImm);
    go();

    // ecall, ack on the 5th io_req cycle, stray pulses elsewhere
    noise = 1'b1; await_n = 4; opcode = OpEcall;
    fetch(0);
    px("ecall_exec", StExec, 7'b0);
    for (int i = 0; i < 5; i++) px("ecall_io", StIoWait, FIOR);
    px("ecall_wb", StWb, FRW | FPW, WbIo, PcPlus4);
    go();
    noise = 1'b0;

    opcode = OpLui;
    fetch(0);
    px("lui_exec", StExec, 7'b0);
    px("lui_wb", StWb, FRW | FPW, WbAlu, PcPlus4);
    go();

    // reset during a long MEM wait
    dwait = 10; opcode = OpIload;
    fetch(0);
    px("lwr_exec", StExec, 7'b0);
    px("lwr_mem", StMem, FDMR);
    px("lwr_mem", StMem, FDMR);
    go();
    rst = 1'b0;
    px("rst_in_mem", StMem, 7'b0);
    exp_cnt = '0;
    px("rst_to_fetch", StFetch, 7'b0);
    go();
    rst = 1'b1; dwait = 0;

    opcode = OpAuipc;
    fetch(0);
    px("auipc_exec", StExec, 7'b0);
    px("auipc_wb", StWb, FRW | FPW, WbAlu, PcPlus4);
    go();

    // illegal opcode: absorbing HALT with no strobes
    opcode = 7'h7F; noise = 1'b1;
    fetch(0);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) px("halt", StHalt, 7'b0);
    go();
    rst = 1'b0;
    px("rst_in_halt", StHalt, 7'b0);
    exp_ill = 1'b0; exp_cnt = '0;
    px("rst_clear_ill", StFetch, 7'b0);
    go();
    rst = 1'b1; noise = 1'b0;

    opcode = OpRtype;
    fetch(0);
    px("add2_exec", StExec, 7'b0);
    px("add2_wb", StWb, FRW | FPW, WbAlu, PcPlus4);
    px("post_fetch", StFetch, FIMR | FIRW);
    go();
    cyc();

    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
